fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage_latch.sv | 38 +++
 rtl/fetch_stage.sv | 63 ++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU word types and the fetch-stage FSM encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;

    // Redirect targets are word addresses; drop any byte offset.
    function automatic word_t word_align(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: icache request/response, hazard and redirect controls, IF/ID outputs.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    logic  if_valid;
    word_t if_instr;
    word_t if_npc;

    modport fs (
        input  ihit, imemload, stall, redirect, redirect_pc, halt,
        output imemREN, imemaddr, if_valid, if_instr, if_npc
    );

    modport tb (
        output ihit, imemload, stall, redirect, redirect_pc, halt,
        input  imemREN, imemaddr, if_valid, if_instr, if_npc
    );

endinterface

// File: rtl/fetch_stage_latch.sv
// IF/ID pipeline latch: load captures a new instruction, flush only clears the valid bit.
module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  flush_i,
    input  word_t instr_i,
    input  word_t npc_i,
    output logic  valid_o,
    output word_t instr_o,
    output word_t npc_o
);

    logic  valid_q;
    word_t instr_q;
    word_t npc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            npc_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            npc_q   <= npc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED FSM and the IF/ID latch.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic      CLK,
    input  logic      RST,
    fetch_stage_if.fs bus
);

    fetch_state_t state_q;
    word_t        pc_q;
    word_t        pc_plus4;
    logic         running;
    logic         lat_load;
    logic         lat_flush;

    assign running  = (state_q == RUN);
    assign pc_plus4 = pc_q + 32'd4;

    // Priority in RUN: redirect > halt > stall > hit/miss.
    assign lat_load  = running && !bus.redirect && !bus.halt && !bus.stall && bus.ihit;
    assign lat_flush = running && (bus.redirect || bus.halt || (!bus.stall && !bus.ihit));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.redirect) begin
                        pc_q <= word_align(bus.redirect_pc);
                    end else if (bus.halt) begin
                        state_q <= HALTED;
                    end else if (!bus.stall && bus.ihit) begin
                        pc_q <= pc_plus4;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
            endcase
        end
    end

    assign bus.imemREN  = running && !RST;
    assign bus.imemaddr = pc_q;

    if_id_latch u_if_id_latch (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (lat_load),
        .flush_i (lat_flush),
        .instr_i (bus.imemload),
        .npc_i   (pc_plus4),
        .valid_o (bus.if_valid),
        .instr_o (bus.if_instr),
        .npc_o   (bus.if_npc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random traffic vs a behavioural model.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam word_t PcInit = 32'h0000_0200;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    fetch_stage_if bus ();

    fetch_stage #(.PC_INIT(PcInit)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        string name;
        logic  ren;
        word_t addr;
        logic  valid;
        word_t instr;
        word_t npc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model state
    word_t m_pc;
    bit    m_halted;
    bit    m_valid;
    word_t m_instr;
    word_t m_npc;

    // Drive one cycle: publish expected outputs for this cycle, then advance the model at the edge.
    task automatic step(input logic rst, input logic hit, input logic stl, input logic rdr,
                        input logic hlt, input word_t load, input word_t rpc, input string name);
        exp_t e;
        RST             = rst;
        bus.ihit        = hit;
        bus.stall       = stl;
        bus.redirect    = rdr;
        bus.halt        = hlt;
        bus.imemload    = load;
        bus.redirect_pc = rpc;
        e.name  = name;
        e.ren   = !m_halted && !rst;
        e.addr  = m_pc;
        e.valid = m_valid;
        e.instr = m_instr;
        e.npc   = m_npc;
        exp_q.push_back(e);
        @(posedge CLK);
        if (rst) begin
            m_pc = PcInit; m_halted = 0; m_valid = 0; m_instr = 0; m_npc = 0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (rdr) begin
            m_pc = (rpc / 4) * 4;
            m_valid = 0;
        end else if (hlt) begin
            m_halted = 1;
            m_valid = 0;
        end else if (stl) begin
            // hold everything
        end else if (hit) begin
            m_instr = load;
            m_npc   = m_pc + 4;
            m_pc    = m_pc + 4;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic idle(input string name);
        step(0, 0, 1, 0, 0, 32'h0, 32'h0, name);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (bus.imemREN !== e.ren || bus.imemaddr !== e.addr || bus.if_valid !== e.valid ||
                bus.if_instr !== e.instr || bus.if_npc !== e.npc) begin
                n_fail++;
                $display("FAIL %s: got ren=%b addr=%h v=%b instr=%h npc=%h, want ren=%b addr=%h v=%b instr=%h npc=%h",
                         e.name, bus.imemREN, bus.imemaddr, bus.if_valid, bus.if_instr, bus.if_npc,
                         e.ren, e.addr, e.valid, e.instr, e.npc);
            end
        end
    end

    initial begin
        bus.ihit = 0; bus.stall = 0; bus.redirect = 0; bus.halt = 0;
        bus.imemload = 0; bus.redirect_pc = 0;
        m_pc = PcInit; m_halted = 0; m_valid = 0; m_instr = 0; m_npc = 0;
        RST = 1;
        repeat (2) @(posedge CLK);
        #1;
        step(1, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h0, "reset_state");
        step(0, 0, 0, 0, 0, 32'h0, 32'h0, "after_reset");

        // Straight-line fetch from 0
        step(0, 0, 0, 1, 0, 32'h0, 32'h0, "redir_to_0");
        step(0, 1, 0, 0, 0, 32'hAAAA_0001, 32'h0, "line_A");
        step(0, 1, 0, 0, 0, 32'hBBBB_0002, 32'h0, "line_B");
        step(0, 1, 0, 0, 0, 32'hCCCC_0003, 32'h0, "line_C");
        idle("line_done");

        // Miss at 0x10
        step(0, 0, 0, 1, 0, 32'h0, 32'h10, "redir_to_10");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 32'h1234_5678, 32'h0, "miss_hold");
        step(0, 1, 0, 0, 0, 32'h0101_0101, 32'h0, "miss_fill");
        idle("miss_done");

        // Stall with ihit asserted
        step(0, 1, 1, 0, 0, 32'h5555_5555, 32'h0, "stall_1");
        step(0, 1, 1, 0, 0, 32'h6666_6666, 32'h0, "stall_2");
        idle("stall_done");

        // Redirect beats stall and ihit; unaligned target
        step(0, 1, 1, 1, 0, 32'h7777_7777, 32'h47, "redir_prio");
        idle("redir_prio_done");
        step(0, 1, 0, 1, 1, 32'h8888_8888, 32'h100, "redir_over_halt");
        idle("redir_over_halt_done");

        // PC wrap
        step(0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFE, "redir_top");
        step(0, 1, 0, 0, 0, 32'h9999_9999, 32'h0, "wrap_fetch");
        idle("wrap_done");

        // Halt then everything ignored
        step(0, 1, 0, 0, 1, 32'hABCD_0000, 32'h0, "halt");
        step(0, 1, 0, 1, 0, 32'h0, 32'h80, "halted_redir");
        step(0, 1, 0, 0, 1, 32'h1, 32'h0, "halted_hit");
        idle("halted_idle");

        // Reset mid-miss at 0x30
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, "unhalt_reset");
        step(0, 0, 0, 1, 0, 32'h0, 32'h30, "redir_to_30");
        step(0, 0, 0, 0, 0, 32'h0, 32'h0, "miss_30");
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, "reset_mid_miss");
        step(0, 0, 0, 0, 0, 32'h0, 32'h0, "restart_pcinit");
        step(1, 0, 1, 0, 0, 32'h0, 32'h0, "reset_mid_stall");
        idle("restart_after_stall");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r_rst, r_hit, r_stl, r_rdr, r_hlt;
            r_rst = ($urandom_range(99) < 3);
            r_hlt = ($urandom_range(99) < 3);
            r_rdr = ($urandom_range(99) < 10);
            r_stl = ($urandom_range(99) < 20);
            r_hit = ($urandom_range(99) < 70);
            step(r_rst, r_hit, r_stl, r_rdr, r_hlt, $urandom, $urandom, "random");
        end

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
